// File: rtl/map_probe_arbiter.sv
// Time-shares the map-ROM read port, one wall probe per enemy car, per frame.
// Latency: sum of per-enemy cost (1+ROM_LAT in-map, 1 out-of-map) plus 1 publish cycle.
// Backpressure: none; a frame_tick arriving while busy is dropped and flagged in overrun.
module map_probe_arbiter #(
    parameter int NUM_ENEMY = 4,
    parameter int ROM_LAT   = 1,
    parameter int PROBE     = 17,
    parameter int MAP_W     = 1280,
    parameter int MAP_H     = 960,
    parameter int TILE_COLS = 80
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic [11*NUM_ENEMY-1:0] enemy_x,
    input  logic [11*NUM_ENEMY-1:0] enemy_y,
    input  logic [4*NUM_ENEMY-1:0]  enemy_dir,
    output logic [12:0]            rom_addr,
    output logic                   rom_rd,
    input  logic [4:0]             rom_data,
    output logic [5*NUM_ENEMY-1:0] mapE_on,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);
    localparam int IW = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENEMY - 1);
    localparam logic [10:0] PROBE_D = 11'(PROBE);
    localparam logic [10:0] MAP_W_D = 11'(MAP_W);
    localparam logic [10:0] MAP_H_D = 11'(MAP_H);
    localparam logic [12:0] COLS_D  = 13'(TILE_COLS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAP     = 3'd3;
    localparam logic [2:0] S_PUBLISH = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [1:0]    wait_cnt;
    logic [10:0]   snap_x   [NUM_ENEMY];
    logic [10:0]   snap_y   [NUM_ENEMY];
    logic [3:0]    snap_dir [NUM_ENEMY];
    logic [5*NUM_ENEMY-1:0] shadow, shadow_nxt;

    logic [10:0] cx, cy, px, py;
    logic [3:0]  cd;
    logic        in_map, step_done;
    logic [12:0] tile_addr;

    assign cx = snap_x[idx];
    assign cy = snap_y[idx];
    assign cd = snap_dir[idx];

    // Unsigned wrap is intentional: a probe off the top/left lands above MAP_W/MAP_H.
    always_comb begin
        px = cx;
        py = cy;
        case (cd)
            4'b0001: py = cy - PROBE_D;
            4'b0010: py = cy + PROBE_D;
            4'b0100: px = cx + PROBE_D;
            4'b1000: px = cx - PROBE_D;
            default: ;
        endcase
    end

    assign in_map    = (px < MAP_W_D) && (py < MAP_H_D);
    assign tile_addr = {6'd0, py[10:4]} * COLS_D + {6'd0, px[10:4]};

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_PUBLISH);
    assign rom_rd   = (state == S_ADDR) && in_map;
    assign rom_addr = rom_rd ? tile_addr : 13'd0;

    assign step_done = ((state == S_ADDR) && !in_map) || (state == S_CAP);

    always_comb begin
        shadow_nxt = shadow;
        if ((state == S_ADDR) && !in_map)
            shadow_nxt[int'(idx)*5 +: 5] = 5'b11111;
        else if (state == S_CAP)
            shadow_nxt[int'(idx)*5 +: 5] = rom_data;
    end

    always_ff @(posedge Clk) begin
        if (state == S_IDLE && frame_tick) begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                snap_x[i]   <= enemy_x[11*i +: 11];
                snap_y[i]   <= enemy_y[11*i +: 11];
                snap_dir[i] <= enemy_dir[4*i +: 4];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            shadow   <= '0;
            mapE_on  <= '0;
            overrun  <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (frame_tick && state != S_IDLE)
                overrun <= 1'b1;
            // mapE_on loads on the same edge that enters PUBLISH, so it moves with done.
            if (step_done) begin
                if (idx == LAST_IDX) begin
                    state   <= S_PUBLISH;
                    mapE_on <= shadow_nxt;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= S_ADDR;
                end
            end else begin
                case (state)
                    S_IDLE: if (frame_tick) begin
                        idx   <= '0;
                        state <= S_ADDR;
                    end
                    S_ADDR: begin
                        wait_cnt <= '0;
                        state    <= (ROM_LAT > 1) ? S_WAIT : S_CAP;
                    end
                    S_WAIT: begin
                        if (wait_cnt == 2'(ROM_LAT - 2))
                            state <= S_CAP;
                        else
                            wait_cnt <= wait_cnt + 1'b1;
                    end
                    S_PUBLISH: state <= S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_map_probe_arbiter.sv
// Directed bench for map_probe_arbiter: hand-computed tile addresses, wall codes and cycle counts.
module tb_map_probe_arbiter;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [43:0] enemy_x, enemy_y;
    logic [15:0] enemy_dir;
    logic [12:0] rom_addr;
    logic        rom_rd;
    logic [4:0]  rom_data;
    logic [19:0] mapE_on;
    logic        busy, done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    map_probe_arbiter dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_dir(enemy_dir),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .mapE_on(mapE_on), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] rom_lookup(input logic [12:0] a);
        case (a)
            13'd2260: return 5'b00100;
            13'd486:  return 5'b01001;
            13'd1453: return 5'b10001;
            13'd2510: return 5'b00011;
            default:  return 5'b11110;
        endcase
    endfunction

    // One-cycle ROM; idle pattern 10101 exposes captures taken on the wrong cycle.
    always @(posedge Clk)
        rom_data <= rom_rd ? rom_lookup(rom_addr) : 5'b10101;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Scenario A: all in-map.  (320,440) down, (100,100) none, (200,300) right, (500,500) left.
    localparam logic [43:0] A_X   = {11'd500, 11'd200, 11'd100, 11'd320};
    localparam logic [43:0] A_Y   = {11'd500, 11'd300, 11'd100, 11'd440};
    localparam logic [15:0] A_DIR = {4'b1000, 4'b0100, 4'b0000, 4'b0010};
    localparam logic [19:0] A_MAP = {5'b00011, 5'b10001, 5'b01001, 5'b00100};
    // Scenario B: (320,440) down, (1270,500) right -> out, (600,10) up -> wraps, (100,100) none.
    localparam logic [43:0] B_X   = {11'd100, 11'd600, 11'd1270, 11'd320};
    localparam logic [43:0] B_Y   = {11'd100, 11'd10, 11'd500, 11'd440};
    localparam logic [15:0] B_DIR = {4'b0000, 4'b0001, 4'b0100, 4'b0010};
    localparam logic [19:0] B_MAP = {5'b01001, 5'b11111, 5'b11111, 5'b00100};

    task automatic run_scan(input string tag, input logic [43:0] ex, input logic [43:0] ey,
                            input logic [15:0] ed, input int exp_done, input logic [19:0] exp_map,
                            input logic [19:0] prev_map, input int exp_rd,
                            input logic [51:0] exp_addrs, input int tick_at);
        int done_cyc = 0;
        int rd_cnt = 0;
        logic [12:0] rd_addr [$];
        enemy_x = ex; enemy_y = ey; enemy_dir = ed;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) check_eq({tag, " busy_rise"}, busy, 1);
            if (c == 2) begin
                enemy_x = '0; enemy_y = '0; enemy_dir = {4{4'b0100}};
            end
            if (rom_rd) begin
                rd_cnt++;
                rd_addr.push_back(rom_addr);
            end
            if (c == exp_done - 1) check_eq({tag, " map_before_done"}, mapE_on, prev_map);
            if (done && done_cyc == 0) done_cyc = c;
            if (done_cyc != 0 && c == done_cyc + 1) check_eq({tag, " busy_fall"}, busy, 0);
            frame_tick = (c == tick_at);
            @(negedge Clk);
        end
        frame_tick = 1'b0;
        check_eq({tag, " done_cycle"}, done_cyc, exp_done);
        check_eq({tag, " rd_count"}, rd_cnt, exp_rd);
        check_eq({tag, " mapE_on"}, mapE_on, exp_map);
        for (int k = 0; k < exp_rd && k < rd_addr.size(); k++)
            check_eq($sformatf("%s addr%0d", tag, k), rd_addr[k], exp_addrs[13*k +: 13]);
    endtask

    initial begin
        frame_tick = 1'b0;
        enemy_x = '0; enemy_y = '0; enemy_dir = '0;
        do_reset();
        check_eq("rst rom_addr", rom_addr, 0);
        check_eq("rst rom_rd", rom_rd, 0);
        check_eq("rst mapE_on", mapE_on, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst overrun", overrun, 0);

        run_scan("scanA", A_X, A_Y, A_DIR, 9, A_MAP, 20'd0, 4,
                 {13'd2510, 13'd1453, 13'd486, 13'd2260}, 0);
        check_eq("scanA overrun", overrun, 0);

        run_scan("scanB", B_X, B_Y, B_DIR, 7, B_MAP, A_MAP, 2,
                 {26'd0, 13'd486, 13'd2260}, 0);
        check_eq("scanB overrun", overrun, 0);

        run_scan("tick3", A_X, A_Y, A_DIR, 9, A_MAP, B_MAP, 4,
                 {13'd2510, 13'd1453, 13'd486, 13'd2260}, 3);
        check_eq("tick3 overrun", overrun, 1);

        do_reset();
        check_eq("rst2 overrun", overrun, 0);
        check_eq("rst2 mapE_on", mapE_on, 0);
        run_scan("tick9", A_X, A_Y, A_DIR, 9, A_MAP, 20'd0, 4,
                 {13'd2510, 13'd1453, 13'd486, 13'd2260}, 9);
        check_eq("tick9 overrun", overrun, 1);

        // Reset in cycle 4 of a scan discards it.
        enemy_x = B_X; enemy_y = B_Y; enemy_dir = B_DIR;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("midrst busy", busy, 0);
        check_eq("midrst mapE_on", mapE_on, 0);
        check_eq("midrst rom_rd", rom_rd, 0);
        check_eq("midrst overrun", overrun, 0);
        Reset = 1'b0;
        begin
            int seen_done = 0;
            for (int c = 0; c < 15; c++) begin
                if (done) seen_done++;
                @(negedge Clk);
            end
            check_eq("midrst no_done", seen_done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
